// File: rtl/mem_req_master_pkg.sv
// mem_req_master_pkg: shared widths, command struct and counter-width helper for mem_req_master
package mem_req_master_pkg;
  localparam int MRM_NUM_WORDS  = 64;
  localparam int MRM_DATA_WIDTH = 32;
  localparam int MRM_BYTE_WIDTH = 8;
  localparam int MRM_ADDR_WIDTH = $clog2(MRM_NUM_WORDS);
  localparam int MRM_STRB_WIDTH = MRM_DATA_WIDTH / MRM_BYTE_WIDTH;
  typedef struct packed {
    logic                      write;
    logic [MRM_ADDR_WIDTH-1:0] addr;
    logic [MRM_DATA_WIDTH-1:0] wdata;
    logic [MRM_STRB_WIDTH-1:0] ben;
  } mem_cmd_t;
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/mem_req_master_sync_fifo.sv
// sync_fifo: count-based synchronous FIFO; ports clk_i/rst_i, push_i/data_i in, pop_i/data_o/count_o/empty_o out (data_o is 0 when empty)
module sync_fifo
  import mem_req_master_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int CW = cnt_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_cnt;
  always_ff @(posedge clk_i)
    if (push_i) r_mem[r_wp] <= data_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (push_i) r_wp <= r_wp == PW'(DEPTH - 1) ? '0 : r_wp + PW'(1);
      if (pop_i) r_rp <= r_rp == PW'(DEPTH - 1) ? '0 : r_rp + PW'(1);
      r_cnt <= r_cnt + CW'(push_i) - CW'(pop_i);
    end
  end
  assign empty_o = r_cnt == '0;
  assign count_o = r_cnt;
  assign data_o  = empty_o ? '0 : r_mem[r_rp];
endmodule

// File: rtl/mem_req_master.sv
// mem_req_master: issues client read/write commands to a single-port memory and returns read data in order under credit backpressure
//   clk_i/rst_i: clock, sync active-high reset
//   cmd_*: valid/ready command port (write, addr, wdata, ben)
//   rsp_*: valid/ready read-response port; outstanding_o = reads accepted and not yet popped
//   mem_*: registered memory request port; mem_r_data_i returns LATENCY cycles after a read request
module mem_req_master
  import mem_req_master_pkg::*;
#(
  parameter int NUM_WORDS  = MRM_NUM_WORDS,
  parameter int DATA_WIDTH = MRM_DATA_WIDTH,
  parameter int BYTE_WIDTH = MRM_BYTE_WIDTH,
  parameter int LATENCY    = 1,
  parameter int RSP_DEPTH  = 4,
  localparam int ADDR_WIDTH = $clog2(NUM_WORDS),
  localparam int STRB_WIDTH = DATA_WIDTH / BYTE_WIDTH,
  localparam int CW         = cnt_width(RSP_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  input  logic [STRB_WIDTH-1:0] cmd_ben_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic [CW-1:0]         outstanding_o,
  output logic                  mem_req_o,
  output logic                  mem_w_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_w_data_o,
  output logic [STRB_WIDTH-1:0] mem_b_en_o,
  input  logic [DATA_WIDTH-1:0] mem_r_data_i
);
  if (LATENCY < 1) begin : g_bad_latency
    $error("mem_req_master: LATENCY must be >= 1");
  end
  if (RSP_DEPTH < LATENCY + 2) begin : g_bad_depth
    $error("mem_req_master: RSP_DEPTH must be >= LATENCY+2");
  end
  // The command struct is shared with the package, so data/address widths are fixed there.
  if (DATA_WIDTH != MRM_DATA_WIDTH || ADDR_WIDTH != MRM_ADDR_WIDTH || STRB_WIDTH != MRM_STRB_WIDTH) begin : g_bad_width
    $error("mem_req_master: widths must match mem_req_master_pkg");
  end
  logic               w_acc, w_rd_acc, w_pop, w_issue_rd, w_empty;
  logic [CW-1:0]      r_credit, w_fifo_cnt;
  logic [LATENCY-1:0] r_pipe;
  logic               r_req;
  mem_cmd_t           r_cmd, w_cmd;
  assign cmd_ready_o = !rst_i && (r_credit < CW'(RSP_DEPTH));
  assign w_acc       = cmd_valid_i && cmd_ready_o;
  assign w_rd_acc    = w_acc && !cmd_write_i;
  assign w_pop       = rsp_valid_o && rsp_ready_i;
  assign w_issue_rd  = r_req && !r_cmd.write;
  assign w_cmd = '{write: cmd_write_i, addr: cmd_addr_i,
                   wdata: cmd_write_i ? cmd_wdata_i : '0,
                   ben: cmd_write_i ? cmd_ben_i : '0};
  // r_pipe tags each issued read; bit 0 marks the cycle its data is on mem_r_data_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req    <= 1'b0;
      r_cmd    <= '0;
      r_pipe   <= '0;
      r_credit <= '0;
    end else begin
      r_req    <= w_acc;
      if (w_acc) r_cmd <= w_cmd;
      r_pipe   <= (r_pipe >> 1) | (LATENCY'(w_issue_rd) << (LATENCY - 1));
      r_credit <= r_credit + CW'(w_rd_acc) - CW'(w_pop);
    end
  end
  assign mem_req_o     = r_req;
  assign mem_w_en_o    = r_cmd.write;
  assign mem_addr_o    = r_cmd.addr;
  assign mem_w_data_o  = r_cmd.wdata;
  assign mem_b_en_o    = r_cmd.ben;
  assign outstanding_o = r_credit;
  assign rsp_valid_o   = !w_empty;
  sync_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(DATA_WIDTH)) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (r_pipe[0]),
    .pop_i   (w_pop),
    .data_i  (mem_r_data_i),
    .data_o  (rsp_rdata_o),
    .count_o (w_fifo_cnt),
    .empty_o (w_empty)
  );
  // Buffered responses are a subset of credited reads, so the FIFO can never overflow.
  always_ff @(posedge clk_i)
    if (!rst_i) assert (w_fifo_cnt <= r_credit);
endmodule

// File: tb/tb_mem_req_master.sv
// tb_mem_req_master: directed and random stimulus against a shadow-memory/queue reference model
module tb_mem_req_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_ben;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [2:0]  outstanding;
  logic        mem_req, mem_w_en;
  logic [5:0]  mem_addr;
  logic [31:0] mem_w_data;
  logic [3:0]  mem_b_en;
  logic [31:0] mem_r_data;
  logic        load;
  logic [31:0] seed [64];
  logic [31:0] bus_mem [64];
  logic [31:0] ref_mem [64];
  logic [31:0] q [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_req_master dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_ben_i(cmd_ben),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .outstanding_o(outstanding),
    .mem_req_o(mem_req), .mem_w_en_o(mem_w_en), .mem_addr_o(mem_addr),
    .mem_w_data_o(mem_w_data), .mem_b_en_o(mem_b_en), .mem_r_data_i(mem_r_data)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] ben);
    logic [31:0] r = old_w;
    for (int i = 0; i < 4; i++) if (ben[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  // Memory with one cycle of read latency, as seen by the master.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 64; i++) bus_mem[i] <= seed[i];
      mem_r_data <= '0;
    end else if (mem_req === 1'b1) begin
      if (mem_w_en) bus_mem[mem_addr] <= merge(bus_mem[mem_addr], mem_w_data, mem_b_en);
      else mem_r_data <= bus_mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check and update the reference model mid-cycle, then advance past the edge.
  task automatic tick();
    @(negedge clk);
    if (rst) q.delete();
    else begin
      chk("cmd_ready", cmd_ready, q.size() < 4);
      chk("outstanding", outstanding, q.size());
      if (!rsp_valid) chk("rdata_idle", rsp_rdata, 0);
      if (rsp_valid && rsp_ready) begin
        chk("spurious_rsp", q.size() > 0, 1);
        if (q.size() > 0) chk("rsp_data", rsp_rdata, q.pop_front());
      end
      if (cmd_valid && cmd_ready) begin
        if (cmd_write) ref_mem[cmd_addr] = merge(ref_mem[cmd_addr], cmd_wdata, cmd_ben);
        else q.push_back(ref_mem[cmd_addr]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 20) begin tick(); n++; end
    chk("drain", q.size(), 0);
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 10) begin tick(); n++; end
    chk("wait_rsp", rsp_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] held;
    int n;
    load = 1; rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_ben = 0; rsp_ready = 0;
    for (int i = 0; i < 64; i++) begin seed[i] = $urandom; ref_mem[i] = seed[i]; end
    repeat (3) tick();
    load = 0;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_w_en", mem_w_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_w_data", mem_w_data, 0);
    chk("rst_mem_b_en", mem_b_en, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_outstanding", outstanding, 0);
    rst = 0;
    #1;
    chk("release_ready", cmd_ready, 1);

    rsp_ready = 1; cmd_valid = 1; cmd_write = 1; cmd_addr = 5; cmd_wdata = 32'hDEADBEEF; cmd_ben = 4'hF;
    tick();
    chk("wr_mem_req", mem_req, 1);
    chk("wr_mem_w_en", mem_w_en, 1);
    chk("wr_mem_addr", mem_addr, 5);
    chk("wr_mem_w_data", mem_w_data, 32'hDEADBEEF);
    chk("wr_mem_b_en", mem_b_en, 4'hF);
    cmd_write = 0;
    tick();
    cmd_valid = 0;
    chk("rd_mem_req", mem_req, 1);
    chk("rd_mem_w_en", mem_w_en, 0);
    chk("rd_mem_w_data", mem_w_data, 0);
    chk("rd_mem_b_en", mem_b_en, 0);
    for (int k = 1; k <= 3; k++) begin
      chk("rd_latency", rsp_valid, k == 3);
      if (k == 3) chk("rd_deadbeef", rsp_rdata, 32'hDEADBEEF);
      tick();
    end

    rsp_ready = 0; cmd_valid = 1; cmd_write = 1; cmd_addr = 5; cmd_wdata = 32'h00001234; cmd_ben = 4'b0011;
    tick();
    cmd_write = 0;
    tick();
    cmd_valid = 0;
    wait_rsp();
    chk("partial_write", rsp_rdata, 32'hDEAD1234);
    rsp_ready = 1;
    drain();

    cmd_valid = 1; cmd_write = 0;
    for (int i = 0; i < 64; i++) begin
      cmd_addr = 6'(i);
      chk("b2b_ready", cmd_ready, 1);
      tick();
    end
    cmd_valid = 0;
    drain();

    rsp_ready = 0; cmd_valid = 1; cmd_write = 0;
    for (int i = 0; i < 4; i++) begin
      cmd_addr = 6'($urandom_range(0, 63));
      tick();
    end
    cmd_write = 1; cmd_addr = 7; cmd_wdata = $urandom; cmd_ben = 4'hF;
    chk("bp_ready_low", cmd_ready, 0);
    chk("bp_outstanding", outstanding, 4);
    repeat (4) begin
      tick();
      chk("bp_write_stalled", mem_req, 0);
    end
    chk("bp_rsp_valid", rsp_valid, 1);
    held = rsp_rdata;
    tick();
    chk("bp_rdata_stable", rsp_rdata, held);
    rsp_ready = 1;
    n = 0;
    while (!cmd_ready && n < 10) begin tick(); n++; end
    chk("bp_ready_return", cmd_ready, 1);
    tick();
    cmd_valid = 0;
    chk("bp_write_issue", mem_req, 1);
    chk("bp_write_w_en", mem_w_en, 1);
    chk("bp_write_addr", mem_addr, 7);
    drain();

    for (int i = 0; i < 400; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_write = ($urandom_range(0, 2) == 0);
      cmd_addr  = 6'($urandom_range(0, 15));
      cmd_wdata = $urandom;
      cmd_ben   = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    cmd_valid = 0; rsp_ready = 1;
    drain();

    cmd_valid = 1; cmd_write = 0; cmd_addr = 3;
    tick();
    cmd_addr = 4;
    tick();
    cmd_valid = 0; rst = 1;
    tick();
    rst = 0;
    repeat (6) begin
      chk("rst_mid_valid", rsp_valid, 0);
      chk("rst_mid_outstanding", outstanding, 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
